udp_tx_frame_gen: RTL and testbench

//  Parametrised successor of the UDP send path: builds a complete Ethernet II/IPv4/UDP frame (preamble, SFD, headers,

---
 rtl/udp_tx_frame_gen.sv | 208 ++++++++++++++++++++
 tb/tb_udp_tx_frame_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_frame_gen.sv
// Ethernet II / IPv4 / UDP frame generator onto an 8-bit GMII-style TX bus.
// Define UDP_TX_CHECKSUM_EN to add a payload pre-pass that fills in the UDP checksum.
module udp_tx_frame_gen #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 9,
  parameter int          MAX_PAYLOAD = 1472,
  parameter int          IFG_CYCLES  = 12,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC     = 48'h02_00_00_00_00_02,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP      = 32'hC0A8_0002,
  parameter logic [15:0] SRC_PORT    = 16'h1F90,
  parameter logic [15:0] DST_PORT    = 16'h1F91,
  parameter logic [7:0]  TTL         = 8'h80
) (
  input  logic              g_clk,
  input  logic              reset_n,
  input  logic              i_pkg_send_udp_req,
  input  logic [15:0]       tx_data_length,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              e_txen,
  output logic [7:0]        e_txd,
  output logic              e_txer,
  output logic [3:0]        tx_state,
  output logic              o_busy,
  output logic              o_tx_done,
  output logic              o_len_err
);
  localparam int BPW = DATA_W / 8;

  typedef enum logic [3:0] {
    IDLE = 4'd0, CALC = 4'd1, PRE = 4'd2, ETH = 4'd3, IP = 4'd4, UDP = 4'd5,
    PAY = 4'd6, PAD = 4'd7, FCS = 4'd8, IFG = 4'd9
`ifdef UDP_TX_CHECKSUM_EN
    , CSUM = 4'd10
`endif
  } state_t;

  state_t            state, nstate;
  logic [15:0]       cnt, ncnt, len_q, ident, ip_csum, udp_csum, total_len, udp_len;
  logic [31:0]       hsum, crc;
  logic [DATA_W-1:0] wbuf;
  logic [3:0]        bsel, fsub;
  logic [ADDR_W-1:0] addr;
  logic [335:0]      hdr;
  logic [8:0]        hbit;
  logic [7:0]        tx_byte;
  logic              txen_c, len_err_c, fetch, csum_last;

  function automatic logic [15:0] fold(input logic [31:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {1'b0, s[31:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign total_len   = len_q + 16'd28;
  assign udp_len     = len_q + 16'd8;
  assign hdr         = {DST_MAC, SRC_MAC, 16'h0800,
                        16'h4500, total_len, ident, 16'h4000, TTL, 8'h11, ip_csum, SRC_IP, DST_IP,
                        SRC_PORT, DST_PORT, udp_len, udp_csum};
  assign hbit        = 9'd335 - {cnt[5:0], 3'b000};
  // Address runs two bytes ahead of the payload stream to cover the RAM read latency.
  assign fetch       = (state == UDP && cnt >= 16'd40) || state == PAY;
  assign ram_rd_addr = addr;
  assign tx_state    = state;
  assign o_busy      = (state != IDLE);
  assign e_txer      = 1'b0;

  always_ff @(posedge g_clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end

  always_comb begin
    nstate    = state;
    ncnt      = cnt + 16'd1;
    len_err_c = 1'b0;
    case (state)
      IDLE: begin
        ncnt = '0;
        if (i_pkg_send_udp_req) begin
          if (tx_data_length > 16'(MAX_PAYLOAD)) len_err_c = 1'b1;
          else                                   nstate = CALC;
        end
      end
      CALC: if (cnt == 16'd1) begin
        ncnt = '0;
`ifdef UDP_TX_CHECKSUM_EN
        nstate = CSUM;
`else
        nstate = PRE;
`endif
      end
`ifdef UDP_TX_CHECKSUM_EN
      CSUM: if (csum_last) begin ncnt = '0; nstate = PRE; end
`endif
      PRE:  if (cnt == 16'd7) begin ncnt = '0; nstate = ETH; end
      ETH:  if (cnt == 16'd13) nstate = IP;
      IP:   if (cnt == 16'd33) nstate = UDP;
      UDP:  if (cnt == 16'd41) begin ncnt = '0; nstate = (len_q == 16'd0) ? PAD : PAY; end
      PAY:  if (cnt == len_q - 16'd1) begin ncnt = '0; nstate = (len_q < 16'd18) ? PAD : FCS; end
      PAD:  if (cnt == 16'd17 - len_q) begin ncnt = '0; nstate = FCS; end
      FCS:  if (cnt == 16'd3) begin ncnt = '0; nstate = IFG; end
      IFG:  if (cnt == 16'(IFG_CYCLES - 1)) begin ncnt = '0; nstate = IDLE; end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    txen_c  = 1'b1;
    case (state)
      PRE:         tx_byte = (cnt == 16'd7) ? 8'hD5 : 8'h55;
      ETH, IP, UDP: tx_byte = hdr[hbit -: 8];
      PAY:         tx_byte = wbuf[DATA_W-1 -: 8];
      PAD:         tx_byte = 8'h00;
      FCS:         tx_byte = ~crc[{cnt[1:0], 3'b000} +: 8];
      default:     txen_c  = 1'b0;
    endcase
  end

  assign hsum = 32'h4500 + 32'(total_len) + 32'(ident) + 32'h4000 + 32'({TTL, 8'h11})
              + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);

  always_ff @(posedge g_clk or negedge reset_n)
    if (!reset_n) begin
      len_q <= '0; ident <= '0; ip_csum <= '0; crc <= '0;
      wbuf  <= '0; bsel  <= '0; fsub    <= '0; addr <= '0;
      e_txen <= 1'b0; e_txd <= '0; o_tx_done <= 1'b0; o_len_err <= 1'b0;
    end else begin
      e_txen    <= txen_c;
      e_txd     <= txen_c ? tx_byte : 8'h00;
      o_tx_done <= (state == FCS && cnt == 16'd3);
      o_len_err <= len_err_c;
      if (state == IDLE && nstate == CALC) len_q <= tx_data_length;
      if (state == CALC && cnt == 16'd1)   ip_csum <= ~fold(hsum);
      if (state == IFG && nstate == IDLE)  ident <= ident + 16'd1;
      if (state == PRE)                    crc <= 32'hFFFF_FFFF;
      else if (state inside {ETH, IP, UDP, PAY, PAD}) crc <= crc8(crc, tx_byte);
      if (state == UDP && cnt == 16'd41) begin
        wbuf <= ram_rd_data;
        bsel <= '0;
      end else if (state == PAY) begin
        if (bsel == 4'(BPW - 1)) begin wbuf <= ram_rd_data; bsel <= '0; end
        else begin wbuf <= wbuf << 8; bsel <= bsel + 4'd1; end
      end
      if (fetch) begin
        if (fsub == 4'(BPW - 1)) begin fsub <= '0; addr <= addr + 1'b1; end
        else fsub <= fsub + 4'd1;
      end
`ifdef UDP_TX_CHECKSUM_EN
      else if (state == CSUM) addr <= addr + 1'b1;
`endif
      else begin
        fsub <= '0;
        addr <= '0;
      end
    end

`ifdef UDP_TX_CHECKSUM_EN
  logic [31:0] uacc, uacc_nx;
  logic [15:0] cpos, ufold;

  // Payload bytes at even stream offsets are the high half of a checksum halfword.
  always_comb begin
    uacc_nx = uacc;
    for (int i = 0; i < BPW; i++)
      if ({1'b0, cpos} + 17'(i) < {1'b0, len_q})
        uacc_nx = uacc_nx + (((cpos[0] ^ i[0]) == 1'b1)
                  ? {24'd0, ram_rd_data[DATA_W-1-8*i -: 8]}
                  : {16'd0, ram_rd_data[DATA_W-1-8*i -: 8], 8'd0});
  end

  assign csum_last = (len_q == 16'd0) ||
                     (cnt != 16'd0 && ({1'b0, cpos} + 17'(BPW) >= {1'b0, len_q}));
  assign ufold     = ~fold(uacc_nx);

  always_ff @(posedge g_clk or negedge reset_n)
    if (!reset_n) begin
      uacc <= '0; cpos <= '0; udp_csum <= '0;
    end else begin
      if (state == CALC && cnt == 16'd0) begin
        uacc <= 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0])
              + 32'd17 + 32'(udp_len) + 32'(SRC_PORT) + 32'(DST_PORT) + 32'(udp_len);
        cpos <= '0;
      end else if (state == CSUM && cnt != 16'd0) begin
        uacc <= uacc_nx;
        cpos <= cpos + 16'(BPW);
      end
      if (state == CSUM && csum_last) udp_csum <= (ufold == 16'h0000) ? 16'hFFFF : ufold;
    end
`else
  assign csum_last = 1'b0;
  assign udp_csum  = 16'h0000;
`endif
endmodule

// File: tb/tb_udp_tx_frame_gen.sv
// Scoreboard bench for udp_tx_frame_gen: expected wire bytes are queued per request and popped per txen cycle.
module tb_udp_tx_frame_gen;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 9;
  localparam int          MAXP   = 1472;
  localparam int          IFG    = 12;
  localparam logic [47:0] SMAC   = 48'h02_00_00_AB_CD_01;
  localparam logic [47:0] DMAC   = 48'h10_22_33_44_55_66;
  localparam logic [31:0] SIP    = 32'hC0A8_010A;
  localparam logic [31:0] DIP    = 32'hC0A8_0114;
  localparam logic [15:0] SPORT  = 16'h1F90;
  localparam logic [15:0] DPORT  = 16'h2328;
  localparam logic [7:0]  TTLV   = 8'h80;

  logic              g_clk, reset_n, req;
  logic [15:0]       tx_data_length;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              e_txen, e_txer, o_busy, o_tx_done, o_len_err;
  logic [7:0]        e_txd;
  logic [3:0]        tx_state;

  udp_tx_frame_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PAYLOAD(MAXP), .IFG_CYCLES(IFG),
    .SRC_MAC(SMAC), .DST_MAC(DMAC), .SRC_IP(SIP), .DST_IP(DIP),
    .SRC_PORT(SPORT), .DST_PORT(DPORT), .TTL(TTLV)
  ) dut (
    .g_clk(g_clk), .reset_n(reset_n), .i_pkg_send_udp_req(req), .tx_data_length(tx_data_length),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .e_txen(e_txen), .e_txd(e_txd),
    .e_txer(e_txer), .tx_state(tx_state), .o_busy(o_busy), .o_tx_done(o_tx_done), .o_len_err(o_len_err)
  );

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge g_clk) ram_rd_data <= ram[ram_rd_addr];

  initial begin g_clk = 1'b0; forever #4 g_clk = ~g_clk; end

  int          n_chk, n_err;
  logic [7:0]  exp_q[$];
  logic [7:0]  frm[$];
  logic [15:0] ident_m;
  int          txen_total, pad_total, idle_run;
  bit          had_frame, prev_txen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic put(input logic [63:0] v, input int nb);
    for (int k = nb - 1; k >= 0; k--) frm.push_back(v[8*k +: 8]);
  endtask

  task automatic push_frame(input int len);
    logic [31:0] s, c, w;
    logic [15:0] cs;
    frm.delete();
    put(DMAC, 6); put(SMAC, 6); put(16'h0800, 2);
    put(16'h4500, 2); put(16'(len + 28), 2); put(ident_m, 2); put(16'h4000, 2);
    put({TTLV, 8'h11}, 2); put(16'h0000, 2); put(SIP, 4); put(DIP, 4);
    put(SPORT, 2); put(DPORT, 2); put(16'(len + 8), 2); put(16'h0000, 2);
    s = 0;
    for (int k = 14; k < 34; k += 2) s += {16'd0, frm[k], frm[k+1]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    frm[24] = cs[15:8];
    frm[25] = cs[7:0];
    for (int k = 0; k < len; k++) begin
      w = ram[k / 4];
      frm.push_back(w[31 - 8*(k % 4) -: 8]);
    end
    while (frm.size() < 60) frm.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (frm[k]) c = crc_step(c, frm[k]);
    c = ~c;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (frm[k]) exp_q.push_back(frm[k]);
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    ident_m++;
  endtask

  always @(negedge g_clk) begin
    if (!reset_n) begin
      had_frame = 1'b0;
      prev_txen = 1'b0;
      idle_run  = 0;
    end else begin
      if (tx_state == 4'd7) pad_total++;
      if (e_txen) begin
        if (!prev_txen && had_frame) chk("ifg_gap_ge_12", 32'(idle_run >= IFG), 1);
        txen_total++;
        if (exp_q.size() == 0) chk("unexpected_txen_byte", {24'd0, e_txd}, 32'hFFFF_FFFF);
        else chk("txd", {24'd0, e_txd}, {24'd0, exp_q.pop_front()});
        idle_run = 0;
      end else begin
        if (prev_txen) begin
          had_frame = 1'b1;
          chk("txd_zero_when_idle", {24'd0, e_txd}, 0);
        end
        idle_run++;
      end
      prev_txen = e_txen;
    end
  end

  task automatic send(input int len, input bit poke);
    int lat, n, t0, p0, flen;
    push_frame(len);
    t0 = txen_total;
    p0 = pad_total;
    flen = (42 + len < 60) ? 60 : 42 + len;
    @(negedge g_clk); req = 1'b1; tx_data_length = 16'(len);
    @(negedge g_clk); req = 1'b0;
    lat = 0;
    while (!e_txen && lat < 10) begin @(negedge g_clk); lat++; end
    chk("txen_latency", lat, 3);
    n = 0;
    while (!o_tx_done && n < 4000) begin
      @(negedge g_clk); n++;
      if (poke && n == 30) begin req = 1'b1; tx_data_length = 16'd5; end
      else if (poke && n == 31) begin req = 1'b0; chk("busy_req_no_len_err", o_len_err, 0); end
    end
    chk("tx_done_pulse", o_tx_done, 1);
    @(negedge g_clk);
    chk("tx_done_one_cycle", o_tx_done, 0);
    chk("frame_txen_cycles", txen_total - t0, 8 + flen + 4);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("pad_state_visited", 32'(pad_total != p0), 32'(len < 18));
    n = 1;
    while (o_busy && n < 100) begin @(negedge g_clk); n++; end
    chk("ifg_busy_cycles", n, IFG);
  endtask

  initial begin
    int t0, n;
    n_chk = 0; n_err = 0; ident_m = 16'h0000;
    txen_total = 0; pad_total = 0;
    for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = $urandom;
    ram[0] = 32'hDEAD_BEEF;
    reset_n = 1'b0; req = 1'b0; tx_data_length = '0;
    #21;
    chk("rst_txen", e_txen, 0);
    chk("rst_txd", e_txd, 0);
    chk("rst_state", tx_state, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done_err", {o_tx_done, o_len_err, e_txer}, 0);
    chk("rst_addr", ram_rd_addr, 0);
    @(negedge g_clk); reset_n = 1'b1;
    repeat (2) @(negedge g_clk);

    send(4, 1'b0);
    send(18, 1'b0);
    send(0, 1'b0);
    send(13, 1'b0);

    t0 = txen_total;
    @(negedge g_clk); req = 1'b1; tx_data_length = 16'd1473;
    @(negedge g_clk); req = 1'b0;
    chk("len_err_pulse", o_len_err, 1);
    chk("len_err_not_busy", o_busy, 0);
    @(negedge g_clk);
    chk("len_err_one_cycle", o_len_err, 0);
    repeat (10) @(negedge g_clk);
    chk("len_err_no_txen", txen_total - t0, 0);

    send(1472, 1'b0);
    send(4, 1'b1);
    t0 = txen_total;
    repeat (20) @(negedge g_clk);
    chk("busy_req_ignored", txen_total - t0, 0);
    send(7, 1'b0);
    send(25, 1'b0);

    push_frame(100);
    @(negedge g_clk); req = 1'b1; tx_data_length = 16'd100;
    @(negedge g_clk); req = 1'b0;
    n = 0;
    while (tx_state != 4'd6 && n < 200) begin @(negedge g_clk); n++; end
    chk("reached_pay", tx_state, 6);
    repeat (10) @(negedge g_clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_pay_txen", e_txen, 0);
    chk("rst_mid_pay_state", tx_state, 0);
    chk("rst_mid_pay_busy", o_busy, 0);
    exp_q.delete();
    ident_m = 16'h0000;
    repeat (3) @(negedge g_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge g_clk);
    send(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_chk, n_err);
    $fatal(1);
  end
endmodule
